// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch controller states, fetch-queue entry, NOP encoding.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch <-> decode / instruction-ROM signal bundle.
// master: the fetch unit side; slave: decode stage + ROM side.
interface fetch_unit_if #(
  parameter int IMEM_AW = 9
);
  logic               StallD;
  logic               PCSrcD;
  logic [31:0]        BranchTargetD;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        PCF;
  logic [31:0]        InstrD;
  logic [31:0]        PCPlus4D;
  logic               ValidD;

  modport master (
    input  StallD, PCSrcD, BranchTargetD, imem_data,
    output imem_addr, PCF, InstrD, PCPlus4D, ValidD
  );

  modport slave (
    output StallD, PCSrcD, BranchTargetD, imem_data,
    input  imem_addr, PCF, InstrD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_queue.sv
// 2-entry FIFO of fetched {instr, pc+4}. Head is combinational from storage.
// The caller never pushes when full without a simultaneous pop, and never
// pops when empty; clear wins over push/pop.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  fq_entry_t wdata,
  output fq_entry_t head,
  output logic      full,
  output logic      empty
);

  fq_entry_t  mem [2];
  logic       hd, tl;
  logic [1:0] cnt;

  // Storage, 1-bit toggling pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      hd  <= 1'b0;
      tl  <= 1'b0;
      cnt <= 2'd0;
    end else if (clear) begin
      hd  <= 1'b0;
      tl  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[tl] <= wdata;
        tl      <= ~tl;
      end
      if (pop) hd <= ~hd;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[hd];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, ROM addressing, 2-deep decode
// queue, redirect on taken branch/jump, warm-up bubbles after reset.
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IMEM_AW  = 9,
  parameter int          WARMUP   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      fif,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_redirect,
  output logic [31:0]       perf_bubble
);

  localparam int WCW = $clog2(WARMUP + 1) + 1;

  fetch_state_t   state;
  logic [WCW-1:0] warmCnt;
  logic [31:0]    pcF;
  logic [31:0]    pcPlus4F;
  logic           warmDone;
  logic           valid, pop, redirect, push;
  logic           qFull, qEmpty;
  fq_entry_t      qHead, qWdata;

  assign warmDone = (32'(warmCnt) + 32'd1) >= 32'(WARMUP);
  assign pcPlus4F = pcF + 32'd4;

  assign valid    = !qEmpty;
  assign pop      = valid && !fif.StallD;
  // A branch only redirects once decode actually consumes it.
  assign redirect = (state == RUN) && pop && fif.PCSrcD;
  assign push     = (state == RUN) && !redirect && (!qFull || pop);

  assign qWdata = '{instr: fif.imem_data, pc4: pcPlus4F};

  // Controller: hold WARMUP cycles after reset, then fetch forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WARM;
      warmCnt <= '0;
    end else if (state == WARM) begin
      if (warmDone) state <= RUN;
      else          warmCnt <= warmCnt + 1'b1;
    end
  end

  // PC: redirect has priority; otherwise advance only when a word is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pcF <= PC_RESET;
    else if (redirect) pcF <= fif.BranchTargetD;
    else if (push)     pcF <= pcPlus4F;
  end

  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata (qWdata),
    .head  (qHead),
    .full  (qFull),
    .empty (qEmpty)
  );

  assign fif.PCF       = pcF;
  assign fif.imem_addr = pcF[IMEM_AW+1:2];
  assign fif.ValidD    = valid;
  assign fif.InstrD    = valid ? qHead.instr : NOP_INSTR;
  assign fif.PCPlus4D  = valid ? qHead.pc4   : 32'h0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt, redirCnt, bubbleCnt;

  // Wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCnt  <= '0;
      redirCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (push)                 fetchCnt  <= fetchCnt + 32'd1;
      if (redirect)             redirCnt  <= redirCnt + 32'd1;
      if (!valid && !fif.StallD) bubbleCnt <= bubbleCnt + 32'd1;
    end
  end

  assign perf_fetch    = fetchCnt;
  assign perf_redirect = redirCnt;
  assign perf_bubble   = bubbleCnt;
`else
  assign perf_fetch    = 32'h0;
  assign perf_redirect = 32'h0;
  assign perf_bubble   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table (stall/branch stimulus with
// expected ValidD/PCF) plus an expected-instruction queue for decode output.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.IMEM_AW(9)) fif();
  logic [31:0] perf_fetch, perf_redirect, perf_bubble;

  // ROM word n holds value n.
  assign fif.imem_data = 32'(fif.imem_addr);

  fetch_unit #(.PC_RESET(32'h0), .IMEM_AW(9), .WARMUP(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fif           (fif),
    .perf_fetch    (perf_fetch),
    .perf_redirect (perf_redirect),
    .perf_bubble   (perf_bubble)
  );

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        expV;
    logic [31:0] expPCF;
  } vec_t;

  vec_t      vec [31];
  fq_entry_t expQ [$];
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected decode stream starting at address a.
  task automatic refill(input logic [31:0] a);
    expQ.delete();
    for (int i = 0; i < 48; i++) begin
      expQ.push_back('{instr: (a >> 2) & 32'h1FF, pc4: a + 32'd4});
      a = a + 32'd4;
    end
  endtask

  function automatic vec_t row(input logic s, input logic p, input logic [31:0] t,
                               input logic v, input logic [31:0] pc);
    row = '{stall: s, pcsrc: p, tgt: t, expV: v, expPCF: pc};
  endfunction

  // Apply rows at the negedge, sample 1 ns later, then move to next negedge.
  task automatic runRows(input int first, input int last);
    fq_entry_t e;
    for (int r = first; r <= last; r++) begin
      fif.StallD        = vec[r].stall;
      fif.PCSrcD        = vec[r].pcsrc;
      fif.BranchTargetD = vec[r].tgt;
      #1;
      chk($sformatf("r%0d ValidD", r), 32'(fif.ValidD), 32'(vec[r].expV));
      chk($sformatf("r%0d PCF", r), fif.PCF, vec[r].expPCF);
      if (!vec[r].expV) begin
        chk($sformatf("r%0d InstrD empty", r), fif.InstrD, NOP_INSTR);
        chk($sformatf("r%0d PCPlus4D empty", r), fif.PCPlus4D, 32'h0);
      end else if (!vec[r].stall) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r%0d scoreboard: got consume expected none", r);
        end else begin
          e = expQ.pop_front();
          chk($sformatf("r%0d InstrD", r), fif.InstrD, e.instr);
          chk($sformatf("r%0d PCPlus4D", r), fif.PCPlus4D, e.pc4);
        end
        if (vec[r].pcsrc) refill(vec[r].tgt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // Warm-up, then stream 0,1,2
    for (int i = 0; i < 4; i++) vec[i] = row(0, 0, 0, 0, 32'h0);
    vec[4] = row(0, 0, 0, 1, 32'h4);
    vec[5] = row(0, 0, 0, 1, 32'h8);
    // Three-cycle stall: queue fills, PCF freezes at head PC + 8
    vec[6] = row(1, 0, 0, 1, 32'hC);
    vec[7] = row(1, 0, 0, 1, 32'h10);
    vec[8] = row(1, 0, 0, 1, 32'h10);
    // Full queue, push+pop for 10 cycles (pointer wrap)
    for (int k = 9; k <= 18; k++) vec[k] = row(0, 0, 0, 1, 32'h10 + 32'(4 * (k - 9)));
    // Branch while stalled is ignored; then taken to 0x40
    vec[19] = row(1, 1, 32'h80, 1, 32'h38);
    vec[20] = row(0, 1, 32'h40, 1, 32'h38);
    vec[21] = row(0, 0, 0, 0, 32'h40);
    vec[22] = row(0, 0, 0, 1, 32'h44);
    vec[23] = row(0, 0, 0, 1, 32'h48);
    // Redirect, then PCSrcD during the bubble is ignored
    vec[24] = row(0, 1, 32'h100, 1, 32'h4C);
    vec[25] = row(0, 1, 32'h200, 0, 32'h100);
    vec[26] = row(0, 0, 0, 1, 32'h104);
    // Redirect to top of address space: PC+4 wraps to 0
    vec[27] = row(0, 1, 32'hFFFF_FFFC, 1, 32'h108);
    vec[28] = row(0, 0, 0, 0, 32'hFFFF_FFFC);
    vec[29] = row(0, 0, 0, 1, 32'h0);
    vec[30] = row(0, 0, 0, 1, 32'h4);

    fif.StallD = 1'b0;
    fif.PCSrcD = 1'b0;
    fif.BranchTargetD = 32'h0;

    #1;
    chk("reset PCF", fif.PCF, 32'h0);
    chk("reset ValidD", 32'(fif.ValidD), 32'h0);
    chk("reset InstrD", fif.InstrD, 32'h0);
    chk("reset PCPlus4D", fif.PCPlus4D, 32'h0);
    chk("reset perf_fetch", perf_fetch, 32'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    refill(32'h0);
    runRows(0, 30);

    // Counters before reset (rows 0..30)
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch, 32'd22);
    chk("perf_redirect", perf_redirect, 32'd3);
    chk("perf_bubble", perf_bubble, 32'd7);
`else
    chk("perf_fetch off", perf_fetch, 32'h0);
    chk("perf_redirect off", perf_redirect, 32'h0);
    chk("perf_bubble off", perf_bubble, 32'h0);
`endif
    chk("pre-reset PCF", fif.PCF, 32'h8);

    // Asynchronous reset mid-stream, away from a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async PCF", fif.PCF, 32'h0);
    chk("async ValidD", 32'(fif.ValidD), 32'h0);
    chk("async InstrD", fif.InstrD, 32'h0);
    chk("async PCPlus4D", fif.PCPlus4D, 32'h0);
    chk("async perf_fetch", perf_fetch, 32'h0);
    chk("async perf_redirect", perf_redirect, 32'h0);
    chk("async perf_bubble", perf_bubble, 32'h0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    refill(32'h0);
    runRows(0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the 5-stage MIPS pipeline. It owns the PC register, drives the combinational instruction ROM, and buffers fetched words in a 2-entry queue. The queue head is the decode-stage instruction `InstrD`/`PCPlus4D`. The unit absorbs decode stalls without a separate fetch stall, redirects on taken branches and jumps, and inserts bubbles after reset and after every redirect.

## Interface
Parameters:
- `PC_RESET`, default `32'h0000_0000`: PC value loaded on reset.
- `IMEM_AW`, default 9: instruction-ROM word-address width.
- `WARMUP`, default 3: cycles after reset release before fetching starts.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `StallD` in 1: decode holds its instruction; no pop this cycle.
- `PCSrcD` in 1: taken branch or jump resolved in decode.
- `BranchTargetD` in 32: redirect target.
- `imem_addr` out IMEM_AW: equals `PCF[IMEM_AW+1:2]`.
- `imem_data` in 32: ROM word, combinational from `imem_addr`.
- `PCF` out 32: current fetch PC.
- `InstrD` out 32: queue head instruction; `32'h0` (NOP) when empty.
- `PCPlus4D` out 32: queue head PC+4; 0 when empty.
- `ValidD` out 1: queue non-empty.
- `perf_fetch`, `perf_redirect`, `perf_bubble` out 32 each: performance counters (see Configuration).

## Operation
- Controller states:
  - WARM: entered on reset. Counts `WARMUP` cycles with no push; `PCSrcD` is ignored. Then goes to RUN.
  - RUN: normal fetching.
- Queue: 2 entries of {instr, pc+4}, with head/tail pointers (1 bit) and a count of 0..2. Head outputs are combinational from storage.
- `pop = ValidD && !StallD`.
- `redirect = state==RUN && ValidD && !StallD && PCSrcD`. `PCSrcD` is ignored while `StallD=1` or the queue is empty.
- `push = state==RUN && !redirect && (count<2 || pop)`. On push, the entry is {`imem_data`, `PCF+4`} and `PCF <= PCF+4`.
- With no push and no redirect, `PCF` holds.
- On redirect: `PCF <= BranchTargetD`, the queue is cleared (count 0, pointers 0), and the word fetched this cycle is discarded. The branch at the head counts as consumed.
- Simultaneous push and pop at count 2: count stays 2.
- Pointer wrap: pointers are 1 bit and toggle.
- Arithmetic: PC+4 is 32-bit and wraps modulo 2^32. No alignment check; bits [1:0] are passed through.

## Timing
- Reset values: `PCF=PC_RESET`, count 0, state WARM, `ValidD=0`, `InstrD=0`, `PCPlus4D=0`, all counters 0.
- First push happens in cycle `WARMUP` after reset release. `ValidD` first rises in cycle `WARMUP+1`.
- Push at edge t makes the entry visible at the head from t+1 (1-cycle latency when the queue is empty).
- Redirect at edge t: `PCF=BranchTargetD` from t+1, target pushed at the end of t+1, `ValidD=1` from t+2. This is one bubble cycle in decode.
- Reset asserted mid-operation clears everything immediately (asynchronously) and restarts WARM.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_fetch` increments on each push.
  - `perf_redirect` increments on each redirect.
  - `perf_bubble` increments on each cycle with `!ValidD && !StallD`.
  - All are 32-bit, wrap-around, and reset to 0.
- `FETCH_PERF_CNT_EN` undefined: the counter registers are not built and the three ports are tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - `NOP_INSTR = 32'h0`
  - the fetch state enum (WARM, RUN)
  - the queue entry struct {instr[31:0], pc4[31:0]}
- Sub-module `fetch_queue`: 2-entry FIFO with push, pop, clear and full/empty flags. The controller, PC and counters stay in `fetch_unit`.

## Test plan
- Reset with `WARMUP=3` and `PC_RESET=0`, ROM word n = n: `ValidD=0` for cycles 0–3; at cycle 4 `InstrD=0` and `PCPlus4D=4`; then 1, 2, … on consecutive cycles.
- `StallD` high for 3 cycles in RUN: queue fills to 2, `PCF` freezes at head PC+8, and no instruction is lost or duplicated after release.
- `PCSrcD=1`, `BranchTargetD=0x40`, `StallD=0`: next cycle `PCF=0x40` and `ValidD=0`; the following cycle `InstrD=ROM[16]` and `PCPlus4D=0x44`.
- `PCSrcD=1` together with `StallD=1`: no redirect, and `PCF`/queue behave as for a plain stall.
- Full queue with simultaneous pop and push over 10 cycles: count stays 2 and the instruction order is exact across pointer wrap.
- Async reset pulse mid-stream, with `FETCH_PERF_CNT_EN` defined: all outputs and counters return to 0 at once; before reset `perf_redirect` equals the number of redirects issued and `perf_fetch` equals the number of pushes.
